// File: rtl/rotate_scheduler_if.sv
// Board-side control/status bundle of the rotation scheduler: run/dir/step/load
// requests in, rotation select, change pulse and FSM state out.
interface rotate_scheduler_if;
  logic       RUN;
  logic       DIR;
  logic       STEP;
  logic       LOAD;
  logic [2:0] LOAD_VAL;
  logic [2:0] SEL;
  logic       TICK;
  logic [1:0] STATE;

  modport master (
    output RUN, DIR, STEP, LOAD, LOAD_VAL,
    input  SEL, TICK, STATE
  );

  modport slave (
    input  RUN, DIR, STEP, LOAD, LOAD_VAL,
    output SEL, TICK, STATE
  );
endinterface

// File: rtl/rotate_scheduler.sv
// Generates the rotation select for the 5-digit display mux: prescaled auto-rotate,
// pause, direction, synchronized single-step and direct load. Macro ROT_DWELL_EN adds a hold at position 0.
module rotate_scheduler #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned POSITIONS   = 5,
  parameter int unsigned DWELL_TICKS = 3
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  rotate_scheduler_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [2:0]       SEL_LAST = 3'(POSITIONS - 1);
  localparam logic [3:0]       POS_LIM  = 4'(POSITIONS);

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DWELL   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q, step_prev_q;
  logic             step_pulse;
  logic             tick_int;
  logic             adv;

`ifdef ROT_DWELL_EN
  localparam int unsigned DW_W = (DWELL_TICKS > 0) ? $clog2(DWELL_TICKS + 1) : 1;
  logic [DW_W-1:0] dwell_q, dwell_d;
`else
  if (DWELL_TICKS > 0) begin : g_dwell_unused
  end
`endif

  function automatic logic [2:0] next_sel(input logic [2:0] cur, input logic dir);
    logic [2:0] res;
    if (dir == 1'b0) begin
      res = (cur >= SEL_LAST) ? 3'd0 : cur + 3'd1;
    end else begin
      res = (cur == 3'd0) ? SEL_LAST : cur - 3'd1;
    end
    return res;
  endfunction

  function automatic logic [2:0] load_sel(input logic [2:0] val);
    return ({1'b0, val} < POS_LIM) ? val : 3'd0;
  endfunction

  assign step_pulse = sync2_q & ~step_prev_q;
  assign tick_int   = (state_q != ST_PAUSED) && (cnt_q == CNT_LAST);

  // STEP synchronizer and edge-history registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      sync1_q     <= bus.STEP;
      sync2_q     <= sync1_q;
      step_prev_q <= sync2_q;
    end
  end

  // FSM, select, prescaler and change-pulse registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_PAUSED;
      sel_q   <= 3'd0;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef ROT_DWELL_EN
      dwell_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
`ifdef ROT_DWELL_EN
      dwell_q <= dwell_d;
`endif
    end
  end

  // Next-state logic: LOAD beats a pause request, which beats tick/step advances
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    adv     = 1'b0;
`ifdef ROT_DWELL_EN
    dwell_d = dwell_q;
`endif
    case (state_q)
      ST_PAUSED: begin
        cnt_d = '0;
        if (bus.RUN) begin
          state_d = ST_RUNNING;
        end else begin
          adv = step_pulse;
        end
      end
      ST_RUNNING: begin
        if (!bus.RUN) begin
          state_d = ST_PAUSED;
          cnt_d   = '0;
        end else begin
          cnt_d = tick_int ? '0 : cnt_q + CNT_W'(1);
          adv   = tick_int;
        end
      end
`ifdef ROT_DWELL_EN
      ST_DWELL: begin
        if (!bus.RUN) begin
          state_d = ST_PAUSED;
          cnt_d   = '0;
        end else begin
          cnt_d = tick_int ? '0 : cnt_q + CNT_W'(1);
          if (tick_int) begin
            if (dwell_q <= DW_W'(1)) begin
              dwell_d = '0;
              state_d = ST_RUNNING;
            end else begin
              dwell_d = dwell_q - DW_W'(1);
            end
          end else begin
            dwell_d = dwell_q;
          end
        end
      end
`endif
      default: begin
        state_d = ST_PAUSED;
        cnt_d   = '0;
      end
    endcase

    if (adv) begin
      sel_d = next_sel(sel_q, bus.DIR);
`ifdef ROT_DWELL_EN
      // Only an automatic advance that closes a full cycle starts the hold
      if ((state_q == ST_RUNNING) && (sel_d == 3'd0)) begin
        state_d = ST_DWELL;
        dwell_d = DW_W'(DWELL_TICKS);
      end else begin
        state_d = state_d;
      end
`endif
    end else begin
      sel_d = sel_q;
    end

    if (bus.LOAD) begin
      sel_d   = load_sel(bus.LOAD_VAL);
      cnt_d   = '0;
      state_d = (state_q == ST_DWELL) ? ST_RUNNING : state_q;
    end else begin
      cnt_d = cnt_d;
    end

    tick_d = (sel_d != sel_q);
  end

  assign bus.SEL   = sel_q;
  assign bus.TICK  = tick_q;
  assign bus.STATE = state_q;

endmodule

// File: tb/tb_rotate_scheduler.sv
// Directed bench for rotate_scheduler: stimulus queues expected (SEL, cycle) pairs,
// a negedge monitor pops one per TICK pulse and compares.
module tb_rotate_scheduler;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct {
    logic [2:0] sel;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  rotate_scheduler_if bus_if();

  rotate_scheduler #(
    .TICK_DIV   (4),
    .POSITIONS  (5),
    .DWELL_TICKS(3)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N (rst_n),
    .bus     (bus_if.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every TICK pulse must match the oldest expected change
  always @(negedge clk) begin
    if (bus_if.TICK === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tick_unexpected: SEL=%0d at cycle %0d, no change was expected", bus_if.SEL, cyc);
      end else begin
        e = exp_q.pop_front();
        if (bus_if.SEL !== e.sel || cyc != e.at) begin
          n_fail++;
          $display("FAIL tick_match: got SEL=%0d at cycle %0d, expected SEL=%0d at cycle %0d",
                   bus_if.SEL, cyc, e.sel, e.at);
        end
      end
    end
  end

  task automatic push(input logic [2:0] sel, input int at);
    exp_t x;
    x.sel = sel;
    x.at  = at;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic nxt(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  initial begin
    int c;
    int base;
    bus_if.RUN      = 1'b0;
    bus_if.DIR      = 1'b0;
    bus_if.STEP     = 1'b0;
    bus_if.LOAD     = 1'b0;
    bus_if.LOAD_VAL = 3'd0;
    #1 rst_n = 1'b0;
    nxt(2);
    chk("reset_sel", bus_if.SEL, 0);
    chk("reset_tick", bus_if.TICK, 0);
    chk("reset_state", bus_if.STATE, 0);

    // Forward auto-rotate from reset
    rst_n = 1'b1;
    bus_if.RUN = 1'b1;
    c = cyc;
    push(3'd1, c + 5);
    push(3'd2, c + 9);
    push(3'd3, c + 13);
    push(3'd4, c + 17);
    push(3'd0, c + 21);
    nxt(1);
    chk("run_state", bus_if.STATE, 1);
    nxt(20);

    // Reverse direction, then pause mid-interval and restart
    c = cyc;
    bus_if.DIR = 1'b1;
    push(3'd4, c + 4);
    push(3'd3, c + 8);
    nxt(10);
    bus_if.RUN = 1'b0;
    nxt(1);
    chk("pause_state", bus_if.STATE, 0);
    nxt(6);
    chk("pause_hold_sel", bus_if.SEL, 3);
    c = cyc;
    bus_if.RUN = 1'b1;
    push(3'd2, c + 5);
    nxt(5);
    bus_if.RUN = 1'b0;
    nxt(2);
    chk("paused_again", bus_if.STATE, 0);

    // Held STEP while paused: exactly one advance, three cycles later
    bus_if.DIR = 1'b0;
    c = cyc;
    bus_if.STEP = 1'b1;
    push(3'd3, c + 3);
    nxt(20);
    bus_if.STEP = 1'b0;
    nxt(4);
    chk("step_once_sel", bus_if.SEL, 3);

    // STEP while running adds nothing beyond the timer advance
    c = cyc;
    bus_if.RUN = 1'b1;
    push(3'd4, c + 5);
    nxt(1);
    bus_if.STEP = 1'b1;
    nxt(5);
    bus_if.STEP = 1'b0;
    bus_if.RUN  = 1'b0;
    nxt(4);
    chk("step_running_sel", bus_if.SEL, 4);

    // LOAD coincident with a tick wins; out-of-range value loads 0
    c = cyc;
    bus_if.RUN = 1'b1;
    nxt(4);
    bus_if.LOAD     = 1'b1;
    bus_if.LOAD_VAL = 3'd3;
    push(3'd3, c + 5);
    nxt(1);
    bus_if.LOAD = 1'b0;
    c = cyc;
    push(3'd4, c + 4);
    nxt(5);
    bus_if.LOAD     = 1'b1;
    bus_if.LOAD_VAL = 3'd6;
    push(3'd0, c + 6);
    nxt(1);
    bus_if.LOAD = 1'b0;
    c = cyc;
    push(3'd1, c + 4);
    nxt(4);
    bus_if.RUN = 1'b0;
    nxt(2);
    bus_if.LOAD     = 1'b1;
    bus_if.LOAD_VAL = 3'd1;
    nxt(1);
    bus_if.LOAD = 1'b0;
    nxt(1);
    chk("load_same_sel", bus_if.SEL, 1);
    c = cyc;
    bus_if.LOAD     = 1'b1;
    bus_if.LOAD_VAL = 3'd4;
    push(3'd4, c + 1);
    nxt(1);
    bus_if.LOAD = 1'b0;
    nxt(1);
    chk("load_paused_state", bus_if.STATE, 0);

    // Wrap to position 0: dwell hold when enabled, plain advance otherwise
    c = cyc;
    bus_if.RUN = 1'b1;
    push(3'd0, c + 5);
`ifdef ROT_DWELL_EN
    base = c + 21;
`else
    base = c + 9;
`endif
    push(3'd1, base);
    push(3'd2, base + 4);
    push(3'd3, base + 8);
    nxt(6);
`ifdef ROT_DWELL_EN
    chk("wrap_state", bus_if.STATE, 2);
`else
    chk("wrap_state", bus_if.STATE, 1);
`endif
    nxt(base + 8 - cyc);
    chk("pre_reset_sel", bus_if.SEL, 3);

    // Asynchronous reset with SEL=3 and TICK high
    rst_n = 1'b0;
    #1;
    chk("async_reset_sel", bus_if.SEL, 0);
    chk("async_reset_state", bus_if.STATE, 0);
    chk("async_reset_tick", bus_if.TICK, 0);
    nxt(2);
    rst_n = 1'b1;
    c = cyc;
    push(3'd1, c + 5);
    nxt(6);
    bus_if.RUN = 1'b0;
    nxt(3);
    chk("pending_expectations", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rotate_scheduler.md
Name: rotate_scheduler

Overview:
- Sequences the 5-position character-rotation datapath by generating its 3-bit rotation select (0..4) instead of taking it from switches.
- Advances the select on a prescaled timer tick, with run/pause, direction, manual single-step and direct load.
- Sits between board inputs (CLOCK_50, keys, switches) and the rotation mux select of the 5-digit display path.

Parameters:
- TICK_DIV, 50000000, CLOCK_50 cycles per rotation tick (1 Hz at 50 MHz); minimum 2.
- POSITIONS, 5, number of rotation positions; SEL ranges 0..POSITIONS-1; maximum 8.
- DWELL_TICKS, 3, extra ticks held at position 0 after a full cycle (only with ROT_DWELL_EN).

Ports:
- CLOCK_50  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- RUN  in  1  level; 1 = auto-rotate, 0 = pause.
- DIR  in  1  level; 0 = increment SEL, 1 = decrement SEL.
- STEP  in  1  asynchronous push-button, active high; one advance per press while paused.
- LOAD  in  1  synchronous level; loads LOAD_VAL into SEL.
- LOAD_VAL  in  3  value to load.
- SEL  out  3  rotation select to the mux datapath.
- TICK  out  1  one-cycle pulse on each SEL change.
- STATE  out  2  FSM state code: PAUSED=0, RUNNING=1, DWELL=2.

Behaviour:
- Reset (RESET_N=0, asynchronous): SEL=0, TICK=0, STATE=PAUSED, prescaler=0, STEP synchronizer and edge registers=0.
- STEP path:
  - Two-flop synchronizer, then a rising-edge detector.
  - step_pulse asserts exactly one cycle per 0→1 transition of the synchronized STEP.
  - Latency: 3 cycles from STEP rising to SEL change.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUNNING or DWELL.
  - tick_int asserts on the cycle the count equals TICK_DIV-1; the count then wraps to 0.
  - Held at 0 in PAUSED.
- Advance rule:
  - DIR=0: SEL=POSITIONS-1 wraps to 0, otherwise SEL+1.
  - DIR=1: SEL=0 wraps to POSITIONS-1, otherwise SEL-1.
  - DIR is sampled on the advancing cycle.
- FSM:
  - PAUSED → RUNNING when RUN=1. In PAUSED, step_pulse advances SEL once.
  - RUNNING → PAUSED when RUN=0; the prescaler clears and no advance occurs that cycle. In RUNNING, tick_int advances SEL; step_pulse is ignored.
  - RUNNING → DWELL, with ROT_DWELL_EN only, when an advance lands SEL on 0.
  - DWELL: tick_int decrements dwell_cnt (loaded with DWELL_TICKS on entry) and SEL does not change. When dwell_cnt reaches 0 on a tick, return to RUNNING. RUN=0 → PAUSED.
- LOAD:
  - Highest priority in every state; overrides a coincident tick or step.
  - SEL ← LOAD_VAL if LOAD_VAL < POSITIONS, else 0.
  - Prescaler clears to 0. STATE is unchanged, except DWELL → RUNNING.
- TICK:
  - Registered; high for exactly the one cycle in which SEL takes its new value, including LOAD when the value differs.
  - Low when SEL is unchanged.
- Simultaneous events:
  - LOAD > RUN=0 pause > tick/step advance.
  - RUN rising and step_pulse in the same cycle: enter RUNNING, step ignored.
- Reset mid-rotation: all state returns to reset values immediately, with no partial advance.

Optional Feature:
- Macro: ROT_DWELL_EN.
- Defined: DWELL state present; after each full cycle the message holds at position 0 for DWELL_TICKS extra ticks.
- Undefined: no DWELL state; STATE never reads 2; RUNNING advances on every tick with no pause at 0; DWELL_TICKS is unused.

Test Plan:
1. TICK_DIV=4, DIR=0, RUN=1 from reset:
   - SEL steps 0,1,2,3,4,0 every 4 cycles.
   - TICK pulses each change.
2. TICK_DIV=4, DIR=1, RUN=1:
   - SEL goes 0→4→3 on the first two ticks.
   - RUN=0 mid-count holds SEL; RUN=1 restarts a full 4-cycle interval.
3. Paused, SEL=2, STEP held high 20 cycles:
   - SEL=3 exactly once, 3 cycles after STEP rises.
   - A STEP press while RUNNING produces no extra advance.
4. LOAD=1 with LOAD_VAL=3 on the same cycle as a tick → SEL=3. LOAD_VAL=6 → SEL=0.
5. ROT_DWELL_EN defined, DWELL_TICKS=3, TICK_DIV=4:
   - Reaching SEL=0 gives STATE=2, SEL held 12 cycles, then SEL=1.
   - Undefined: SEL=1 after 4 cycles.
6. RESET_N pulsed low asynchronously mid-interval with SEL=3 → SEL=0, STATE=0, TICK=0 immediately.
